// File: rtl/mac3_pkg.sv
// Shared FSM encoding and width helpers for the sequential sum-of-three-products engine.
// No logic of its own: no latency and no flow control.
package mac3_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P0   = 3'd1,
        P1   = 3'd2,
        P2   = 3'd3,
        W    = 3'd4,
        FIN  = 3'd5
    } state_t;

    // Room for three full-scale products without overflow.
    function automatic int acc_width(input int width);
        return 2 * width + 2;
    endfunction

endpackage

// File: rtl/mul_unit.sv
// Unsigned WIDTH x WIDTH multiplier with an optional output register stage.
// Latency: 0 cycles (MUL_PIPE=0) or 1 cycle (MUL_PIPE=1); no backpressure, valid follows the data.
module mul_unit #(
    parameter int WIDTH    = 8,
    parameter int MUL_PIPE = 0
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               i_vld,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_vld,
    output logic [2*WIDTH-1:0] o_prod
);

    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] r_prod;
    logic               r_vld;

    assign w_prod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_prod <= '0;
            r_vld  <= 1'b0;
        end else begin
            r_prod <= w_prod;
            r_vld  <= i_vld;
        end
    end

    assign o_prod = (MUL_PIPE != 0) ? r_prod : w_prod;
    assign o_vld  = (MUL_PIPE != 0) ? r_vld  : i_vld;

endmodule

// File: rtl/mac3_sequencer.sv
// Computes A*B + C*D + E*F through one shared multiplier, one operand pair per cycle.
// Latency: done 4 (MUL_PIPE=0) or 5 (MUL_PIPE=1) cycles after the start edge; start is ignored unless IDLE.
module mac3_sequencer
    import mac3_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int ACC_W    = acc_width(WIDTH),
    parameter int MUL_PIPE = 0
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] E,
    input  logic [WIDTH-1:0] F,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] out
);

    state_t               r_state;
    logic [WIDTH-1:0]     r_a, r_b, r_c, r_d, r_e, r_f;
    logic [ACC_W-1:0]     r_acc;
    logic [ACC_W-1:0]     r_out;
    logic                 r_busy;
    logic                 r_done;

    logic [WIDTH-1:0]     w_mul_a;
    logic [WIDTH-1:0]     w_mul_b;
    logic                 w_mul_vld;
    logic [2*WIDTH-1:0]   w_prod;
    logic                 w_prod_vld;

    // Operand pair steered to the shared multiplier by the current phase.
    always_comb begin
        w_mul_a   = '0;
        w_mul_b   = '0;
        w_mul_vld = 1'b0;
        case (r_state)
            P0: begin w_mul_a = r_a; w_mul_b = r_b; w_mul_vld = 1'b1; end
            P1: begin w_mul_a = r_c; w_mul_b = r_d; w_mul_vld = 1'b1; end
            P2: begin w_mul_a = r_e; w_mul_b = r_f; w_mul_vld = 1'b1; end
            default: ;
        endcase
    end

    mul_unit #(
        .WIDTH    (WIDTH),
        .MUL_PIPE (MUL_PIPE)
    ) u_mul (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_vld     (w_mul_vld),
        .i_a       (w_mul_a),
        .i_b       (w_mul_b),
        .o_vld     (w_prod_vld),
        .o_prod    (w_prod)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_e     <= '0;
            r_f     <= '0;
            r_acc   <= '0;
            r_out   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_prod_vld) begin
                r_acc <= r_acc + {{(ACC_W-2*WIDTH){1'b0}}, w_prod};
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_c     <= C;
                        r_d     <= D;
                        r_e     <= E;
                        r_f     <= F;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= P0;
                    end
                end
                P0: r_state <= P1;
                P1: r_state <= P2;
                // With a piped multiplier the last product lands one cycle later.
                P2: r_state <= (MUL_PIPE != 0) ? W : FIN;
                W:  r_state <= FIN;
                FIN: begin
                    r_out   <= r_acc;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign out  = r_out;

endmodule

// File: tb/tb_mac3_sequencer.sv
// Directed bench for mac3_sequencer, exercising one instance per multiplier pipeline setting.
module tb_mac3_sequencer;

    logic        clk;
    logic        rst_n;
    logic [1:0]  st;
    logic [7:0]  op [2][6];
    logic [1:0]  w_busy;
    logic [1:0]  w_done;
    logic [17:0] w_out [2];

    int checks;
    int failures;
    int n_done [2];
    int n_exp  [2];
    int q0 [$];
    int q1 [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mac3_sequencer #(.WIDTH(8), .ACC_W(18), .MUL_PIPE(0)) dut0 (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(st[0]),
        .A(op[0][0]), .B(op[0][1]), .C(op[0][2]), .D(op[0][3]), .E(op[0][4]), .F(op[0][5]),
        .busy(w_busy[0]), .done(w_done[0]), .out(w_out[0])
    );

    mac3_sequencer #(.WIDTH(8), .ACC_W(18), .MUL_PIPE(1)) dut1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(st[1]),
        .A(op[1][0]), .B(op[1][1]), .C(op[1][2]), .D(op[1][3]), .E(op[1][4]), .F(op[1][5]),
        .busy(w_busy[1]), .done(w_done[1]), .out(w_out[1])
    );

    task automatic chk(input string tag, input int p, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s pipe=%0d observed=%0d expected=%0d", tag, p, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int qsize(input int p);
        return (p == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push_exp(input int p, input int v);
        if (p == 0) q0.push_back(v);
        else        q1.push_back(v);
        n_exp[p]++;
    endtask

    task automatic set_ops(input int p, input int a, input int b, input int c,
                           input int d, input int e, input int f);
        op[p][0] = 8'(a); op[p][1] = 8'(b); op[p][2] = 8'(c);
        op[p][3] = 8'(d); op[p][4] = 8'(e); op[p][5] = 8'(f);
    endtask

    // Drives a one-cycle start; returns just after the accepting edge.
    task automatic start_job(input int p, input int a, input int b, input int c,
                             input int d, input int e, input int f);
        set_ops(p, a, b, c, d, e, f);
        push_exp(p, a * b + c * d + e * f);
        st[p] = 1'b1;
        step();
        st[p] = 1'b0;
    endtask

    task automatic drain(input int p);
        for (int i = 0; i < 20; i++) begin
            if (qsize(p) == 0) break;
            step();
        end
        step();
        chk("drain_pending", p, qsize(p), 0);
        chk("done_count", p, n_done[p], n_exp[p]);
    endtask

    // Scoreboard: every done pulse must match the next queued result.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int p = 0; p < 2; p++) begin
                if (w_done[p]) begin
                    n_done[p]++;
                    if (qsize(p) == 0) chk("spurious_done", p, 32'(w_done[p]), 0);
                    else if (p == 0)   chk("out", p, 32'(w_out[0]), q0.pop_front());
                    else               chk("out", p, 32'(w_out[1]), q1.pop_front());
                end
            end
        end
    end

    initial begin
        int lat;
        checks   = 0;
        failures = 0;
        n_done   = '{0, 0};
        n_exp    = '{0, 0};
        st       = 2'b00;
        rst_n    = 1'b1;
        for (int p = 0; p < 2; p++) set_ops(p, 0, 0, 0, 0, 0, 0);

        for (int p = 0; p < 2; p++) begin
            lat = 4 + p;

            rst_n = 1'b0;
            step();
            step();
            chk("rst_busy", p, 32'(w_busy[p]), 0);
            chk("rst_done", p, 32'(w_done[p]), 0);
            chk("rst_out",  p, 32'(w_out[p]), 0);
            rst_n = 1'b1;
            step();

            // T1: latency and basic result
            start_job(p, 52, 125, 100, 98, 20, 15);
            chk("t1_busy_start", p, 32'(w_busy[p]), 1);
            chk("t1_done_early", p, 32'(w_done[p]), 0);
            repeat (lat - 1) step();
            chk("t1_busy_fin", p, 32'(w_busy[p]), 1);
            chk("t1_done_fin", p, 32'(w_done[p]), 0);
            step();
            chk("t1_done", p, 32'(w_done[p]), 1);
            chk("t1_busy_done", p, 32'(w_busy[p]), 0);
            step();
            chk("t1_done_pulse", p, 32'(w_done[p]), 0);
            drain(p);

            // T2: back-to-back, second start on the first IDLE cycle
            start_job(p, 48, 201, 66, 54, 99, 52);
            repeat (lat) step();
            chk("t2_done1", p, 32'(w_done[p]), 1);
            start_job(p, 86, 114, 126, 88, 123, 81);
            chk("t2_done1_pulse", p, 32'(w_done[p]), 0);
            chk("t2_busy2", p, 32'(w_busy[p]), 1);
            drain(p);

            // T3: extremes
            start_job(p, 255, 255, 255, 255, 255, 255);
            drain(p);
            start_job(p, 0, 0, 0, 0, 0, 0);
            drain(p);

            // T4: start held high; operands changed mid-job
            set_ops(p, 10, 20, 30, 40, 50, 60);
            push_exp(p, 10 * 20 + 30 * 40 + 50 * 60);
            st[p] = 1'b1;
            step();
            step();
            set_ops(p, 7, 9, 11, 13, 200, 3);
            chk("t4_busy_p1", p, 32'(w_busy[p]), 1);
            repeat (lat - 2) step();
            chk("t4_busy_fin", p, 32'(w_busy[p]), 1);
            step();
            chk("t4_done", p, 32'(w_done[p]), 1);
            chk("t4_no_fin_accept", p, 32'(w_busy[p]), 0);
            push_exp(p, 7 * 9 + 11 * 13 + 200 * 3);
            step();
            st[p] = 1'b0;
            chk("t4_retrigger", p, 32'(w_busy[p]), 1);
            drain(p);

            // T5: reset during P1 aborts the job
            set_ops(p, 200, 200, 200, 200, 200, 200);
            st[p] = 1'b1;
            step();
            st[p] = 1'b0;
            step();
            rst_n = 1'b0;
            #1;
            chk("t5_busy", p, 32'(w_busy[p]), 0);
            chk("t5_out", p, 32'(w_out[p]), 0);
            chk("t5_done", p, 32'(w_done[p]), 0);
            step();
            rst_n = 1'b1;
            repeat (lat + 3) step();
            chk("t5_no_done", p, n_done[p], n_exp[p]);

            // T6: start during FIN ignored
            start_job(p, 1, 2, 3, 4, 5, 6);
            repeat (lat - 1) step();
            st[p] = 1'b1;
            step();
            st[p] = 1'b0;
            chk("t6_done", p, 32'(w_done[p]), 1);
            chk("t6_busy", p, 32'(w_busy[p]), 0);
            step();
            chk("t6_busy_next", p, 32'(w_busy[p]), 0);
            drain(p);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
